// File: rtl/l2_line_transfer_master_if.sv
// L2 line bus bundle: the cache-side refill/writeback request ports and the
// L2-side read-address, read-data and write-burst channels.
// The master modport is the line transfer master. The slave modport is the cache and L2 around it.
interface l2_line_transfer_master_if #(
    parameter int B          = 9,
    parameter int W          = 7,
    parameter int ADDR_WIDTH = 32
);
    // Cache-side refill request and returned line
    logic                    refill_req_valid;
    logic                    refill_req_ready;
    logic [ADDR_WIDTH-3:0]   refill_addr;
    logic [(2**B)-1:0]       refill_data;
    logic                    refill_done;

    // Cache-side writeback request
    logic                    wb_req_valid;
    logic                    wb_req_ready;
    logic [ADDR_WIDTH-3:0]   wb_addr;
    logic [(2**B)-1:0]       wb_data;
    logic                    wb_done;

    // L2 read address and read data channels
    logic                    rd_addr_to_l2_valid;
    logic                    rd_addr_to_l2_ready;
    logic [ADDR_WIDTH-3:0]   rd_addr_to_l2;
    logic                    data_from_l2_valid;
    logic                    data_from_l2_ready;
    logic [(2**W)-1:0]       data_from_l2;

    // L2 write burst channel and completion acknowledge
    logic                    wr_to_l2_valid;
    logic                    wr_to_l2_ready;
    logic [ADDR_WIDTH-3:0]   wr_addr_to_l2;
    logic [(2**W)-1:0]       data_to_l2;
    logic                    wr_control_to_l2;
    logic                    wr_complete;

    modport master (
        input  refill_req_valid, refill_addr,
        input  wb_req_valid, wb_addr, wb_data,
        input  rd_addr_to_l2_ready, data_from_l2_valid, data_from_l2,
        input  wr_to_l2_ready, wr_complete,
        output refill_req_ready, refill_data, refill_done,
        output wb_req_ready, wb_done,
        output rd_addr_to_l2_valid, rd_addr_to_l2, data_from_l2_ready,
        output wr_to_l2_valid, wr_addr_to_l2, data_to_l2, wr_control_to_l2
    );

    modport slave (
        output refill_req_valid, refill_addr,
        output wb_req_valid, wb_addr, wb_data,
        output rd_addr_to_l2_ready, data_from_l2_valid, data_from_l2,
        output wr_to_l2_ready, wr_complete,
        input  refill_req_ready, refill_data, refill_done,
        input  wb_req_ready, wb_done,
        input  rd_addr_to_l2_valid, rd_addr_to_l2, data_from_l2_ready,
        input  wr_to_l2_valid, wr_addr_to_l2, data_to_l2, wr_control_to_l2
    );
endinterface

// File: rtl/l2_line_transfer_master.sv
// L1-side initiator for the L2 line bus.
// The read engine turns a refill into an address handshake plus a burst of read beats.
// The write engine turns a writeback into a write burst, then waits for WR_COMPLETE.
// The two engines run concurrently. A refill to a line that is still being
// written back waits until that writeback has been acknowledged.
module l2_line_transfer_master #(
    parameter int B          = 9,
    parameter int W          = 7,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    l2_line_transfer_master_if.master bus
);

    localparam int AW        = ADDR_WIDTH - 2;     // word-address width
    localparam int LW        = 2**B;               // line width in bits
    localparam int DW        = 2**W;               // bus beat width in bits
    localparam int BURST     = 2**(B - W);         // beats per line
    localparam int CW        = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int LINE_WRDS = 2**(B - 5);         // 32-bit words per line

    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
    // Clears the word-within-line bits to give a line-aligned word address
    localparam logic [AW-1:0] LINE_MASK = ~AW'(LINE_WRDS - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_DONE
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_WAIT,
        W_DONE
    } wr_state_e;

    // Read engine state
    rd_state_e       rstate_q, rstate_d;
    logic [AW-1:0]   raddr_q,  raddr_d;
    logic [CW-1:0]   rcnt_q,   rcnt_d;
    logic [LW-1:0]   rline_q,  rline_d;

    // Write engine state
    wr_state_e       wstate_q, wstate_d;
    logic [AW-1:0]   waddr_q,  waddr_d;
    logic [CW-1:0]   wcnt_q,   wcnt_d;
    logic [LW-1:0]   wline_q,  wline_d;

    // High from the first cycle after reset; gates every ready output
    logic            active_q;

    logic            hazard;
    logic            refill_ready;
    logic            refill_acc;
    logic            wb_ready;
    logic            wb_acc;
    logic            rd_beat;
    logic            wr_beat;

    // Out-of-reset flag so all outputs, readies included, read 0 while reset is applied
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples
        // pre-edge values and process ordering cannot change the result.
        if (rst) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    // Read-after-write ordering and request handshakes
    always_comb begin
        hazard = (((bus.refill_addr & LINE_MASK) == waddr_q) && (wstate_q != W_IDLE))
              || (bus.wb_req_valid &&
                  ((bus.refill_addr & LINE_MASK) == (bus.wb_addr & LINE_MASK)));
        refill_ready = active_q && (rstate_q == R_IDLE) && !hazard;
        refill_acc   = refill_ready && bus.refill_req_valid;
        wb_ready     = active_q && (wstate_q == W_IDLE);
        wb_acc       = wb_ready && bus.wb_req_valid;
        rd_beat      = active_q && bus.data_from_l2_valid;
        wr_beat      = (wstate_q == W_DATA) && bus.wr_to_l2_ready;
    end

    assign bus.refill_req_ready   = refill_ready;
    assign bus.wb_req_ready       = wb_ready;
    assign bus.data_from_l2_ready = active_q;
    assign bus.rd_addr_to_l2      = raddr_q;
    assign bus.refill_data        = rline_q;
    assign bus.wr_addr_to_l2      = waddr_q;
    assign bus.data_to_l2         = wline_q[int'(wcnt_q) * DW +: DW];

    // Read engine state register
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the line buffers are reset on purpose: REFILL_DATA and DATA_TO_L2
            // are outputs and must read 0 after reset, not leftover line contents.
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rcnt_q   <= '0;
            rline_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            raddr_q  <= raddr_d;
            rcnt_q   <= rcnt_d;
            rline_q  <= rline_d;
        end
    end

    // Read engine next state and outputs: address handshake, beat assembly, done pulse
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        rstate_d                = rstate_q;
        raddr_d                 = raddr_q;
        rcnt_d                  = rcnt_q;
        rline_d                 = rline_q;
        bus.rd_addr_to_l2_valid = 1'b0;
        bus.refill_done         = 1'b0;

        unique case (rstate_q)
            R_IDLE: begin
                if (refill_acc) begin
                    raddr_d  = bus.refill_addr & LINE_MASK;
                    rcnt_d   = '0;
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                // Beats arriving before the address is accepted are dropped
                bus.rd_addr_to_l2_valid = 1'b1;
                if (bus.rd_addr_to_l2_ready) begin
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rd_beat) begin
                    rline_d[int'(rcnt_q) * DW +: DW] = bus.data_from_l2;
                    if (rcnt_q == LAST_BEAT) begin
                        rcnt_d   = '0;
                        rstate_d = R_DONE;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            R_DONE: begin
                bus.refill_done = 1'b1;
                rstate_d        = R_IDLE;
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    // Write engine state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            waddr_q  <= '0;
            wcnt_q   <= '0;
            wline_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            waddr_q  <= waddr_d;
            wcnt_q   <= wcnt_d;
            wline_q  <= wline_d;
        end
    end

    // Write engine next state and outputs: burst out, wait for completion, done pulse
    always_comb begin
        wstate_d             = wstate_q;
        waddr_d              = waddr_q;
        wcnt_d               = wcnt_q;
        wline_d              = wline_q;
        bus.wr_to_l2_valid   = 1'b0;
        bus.wr_control_to_l2 = 1'b0;
        bus.wb_done          = 1'b0;

        unique case (wstate_q)
            W_IDLE: begin
                if (wb_acc) begin
                    waddr_d  = bus.wb_addr & LINE_MASK;
                    wline_d  = bus.wb_data;
                    wcnt_d   = '0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                // Beat and last flag come from registered state, so they hold under backpressure
                bus.wr_to_l2_valid   = 1'b1;
                bus.wr_control_to_l2 = (wcnt_q == LAST_BEAT);
                if (wr_beat) begin
                    if (wcnt_q == LAST_BEAT) begin
                        wcnt_d   = '0;
                        wstate_d = W_WAIT;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            W_WAIT: begin
                // WR_COMPLETE only counts here; pulses in any other state are ignored
                if (bus.wr_complete) begin
                    wstate_d = W_DONE;
                end
            end
            W_DONE: begin
                bus.wb_done = 1'b1;
                wstate_d    = W_IDLE;
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_line_transfer_master.sv
// Directed bench for l2_line_transfer_master with B=9, W=7, so BURST=4.
// Inputs change 1 ns after the rising edge.
// Outputs are sampled at that point, or 1 ns later when they depend on inputs just driven.
module tb_l2_line_transfer_master;

    localparam int B  = 9;
    localparam int W  = 7;
    localparam int AW = 30;
    localparam int DW = 128;
    localparam int LW = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    l2_line_transfer_master_if #(.B(B), .W(W), .ADDR_WIDTH(32)) bus ();

    l2_line_transfer_master #(.B(B), .W(W), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Done pulses observed mid-cycle, compared as differences by the tests
    int refill_pulses = 0;
    int wb_pulses     = 0;

    always @(negedge clk) begin
        if (bus.refill_done === 1'b1) refill_pulses++;
        if (bus.wb_done === 1'b1) wb_pulses++;
    end

    // Hard stop in case some scenario loses track of the DUT
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.refill_req_valid    = 1'b0;
        bus.refill_addr         = '0;
        bus.wb_req_valid        = 1'b0;
        bus.wb_addr             = '0;
        bus.wb_data             = '0;
        bus.rd_addr_to_l2_ready = 1'b0;
        bus.data_from_l2_valid  = 1'b0;
        bus.data_from_l2        = '0;
        bus.wr_to_l2_ready      = 1'b0;
        bus.wr_complete         = 1'b0;
    endtask

    // Drives the four read beats base..base+3, each preceded by 'gap' idle cycles.
    // Returns in the cycle after the last beat was taken.
    task automatic feed_beats(input logic [DW-1:0] base, input int gap);
        for (int k = 0; k < 4; k++) begin
            repeat (gap) tick();
            bus.data_from_l2_valid = 1'b1;
            bus.data_from_l2       = base + DW'(k);
            tick();
            bus.data_from_l2_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.refill_req_ready, bus.wb_req_ready, bus.data_from_l2_ready,
             bus.rd_addr_to_l2_valid, bus.wr_to_l2_valid, bus.wr_control_to_l2,
             bus.refill_done, bus.wb_done} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {bus.refill_req_ready, bus.wb_req_ready, bus.data_from_l2_ready,
                      bus.rd_addr_to_l2_valid, bus.wr_to_l2_valid, bus.wr_control_to_l2,
                      bus.refill_done, bus.wb_done});
        end
        checks++;
        if (bus.refill_data !== '0 || bus.data_to_l2 !== '0 ||
            bus.rd_addr_to_l2 !== '0 || bus.wr_addr_to_l2 !== '0) begin
            errors++;
            $display("FAIL reset_data: refill_data=%h data_to_l2=%h rd_addr=%h wr_addr=%h expected all 0",
                     bus.refill_data, bus.data_to_l2, bus.rd_addr_to_l2, bus.wr_addr_to_l2);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.refill_req_ready, bus.wb_req_ready, bus.data_from_l2_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release: readies got %b expected 111",
                     {bus.refill_req_ready, bus.wb_req_ready, bus.data_from_l2_ready});
        end
    endtask

    // Refill of 30'h40, beats A0..A3 every 7 cycles
    task automatic test_refill();
        logic [LW-1:0] exp_line;
        int            p0;
        exp_line = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
        p0 = refill_pulses;
        bus.rd_addr_to_l2_ready = 1'b1;
        bus.refill_req_valid    = 1'b1;
        bus.refill_addr         = 30'h40;
        #1;
        checks++;
        if (bus.refill_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL refill_ready: got %b expected 1", bus.refill_req_ready);
        end
        tick();
        bus.refill_req_valid = 1'b0;
        checks++;
        if (bus.rd_addr_to_l2_valid !== 1'b1 || bus.rd_addr_to_l2 !== 30'h40) begin
            errors++;
            $display("FAIL refill_addr: valid=%b addr=%h expected 1 / 00000040",
                     bus.rd_addr_to_l2_valid, bus.rd_addr_to_l2);
        end
        tick();
        feed_beats(128'hA0, 6);
        checks++;
        if (bus.refill_done !== 1'b1 || bus.refill_data !== exp_line) begin
            errors++;
            $display("FAIL refill_done: done=%b data=%h expected 1 / %h",
                     bus.refill_done, bus.refill_data, exp_line);
        end
        tick();
        checks++;
        if (bus.refill_done !== 1'b0 || refill_pulses - p0 != 1) begin
            errors++;
            $display("FAIL refill_pulse: done=%b pulses=%0d expected 0 / 1",
                     bus.refill_done, refill_pulses - p0);
        end
    endtask

    // Stray beats in R_IDLE and R_ADDR are dropped; the address is held while READY is low
    task automatic test_stray_beats();
        logic [LW-1:0] prev_line;
        logic [LW-1:0] exp_line;
        prev_line = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
        exp_line  = {128'hB3, 128'hB2, 128'hB1, 128'hB0};
        bus.data_from_l2_valid = 1'b1;
        bus.data_from_l2       = {4{32'hFFFF_EEEE}};
        tick();
        tick();
        bus.data_from_l2_valid = 1'b0;
        checks++;
        if (bus.refill_data !== prev_line) begin
            errors++;
            $display("FAIL stray_idle: data=%h expected %h", bus.refill_data, prev_line);
        end
        bus.rd_addr_to_l2_ready = 1'b0;
        bus.refill_req_valid    = 1'b1;
        bus.refill_addr         = 30'h47;
        tick();
        bus.refill_req_valid   = 1'b0;
        bus.data_from_l2_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.rd_addr_to_l2_valid !== 1'b1 || bus.rd_addr_to_l2 !== 30'h40) begin
                errors++;
                $display("FAIL addr_hold: cycle %0d valid=%b addr=%h expected 1 / 00000040",
                         i, bus.rd_addr_to_l2_valid, bus.rd_addr_to_l2);
            end
            tick();
        end
        bus.data_from_l2_valid  = 1'b0;
        bus.rd_addr_to_l2_ready = 1'b1;
        tick();
        feed_beats(128'hB0, 0);
        checks++;
        if (bus.refill_done !== 1'b1 || bus.refill_data !== exp_line) begin
            errors++;
            $display("FAIL stray_refill: done=%b data=%h expected 1 / %h",
                     bus.refill_done, bus.refill_data, exp_line);
        end
        tick();
    endtask

    // Writeback of 30'h85: base 30'h80, beats D0..D3, last flag on D3 only
    task automatic test_writeback();
        logic [DW-1:0] bt [4];
        int            p0;
        for (int k = 0; k < 4; k++) bt[k] = {4{32'hD0D0_0000}} + DW'(k);
        p0 = wb_pulses;
        bus.wr_to_l2_ready = 1'b1;
        bus.wb_req_valid   = 1'b1;
        bus.wb_addr        = 30'h85;
        bus.wb_data        = {bt[3], bt[2], bt[1], bt[0]};
        #1;
        checks++;
        if (bus.wb_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wb_ready: got %b expected 1", bus.wb_req_ready);
        end
        tick();
        bus.wb_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.wr_to_l2_valid !== 1'b1 || bus.data_to_l2 !== bt[k] ||
                bus.wr_control_to_l2 !== (k == 3) || bus.wr_addr_to_l2 !== 30'h80) begin
                errors++;
                $display("FAIL wb_beat%0d: valid=%b data=%h last=%b addr=%h expected 1 / %h / %b / 00000080",
                         k, bus.wr_to_l2_valid, bus.data_to_l2, bus.wr_control_to_l2,
                         bus.wr_addr_to_l2, bt[k], (k == 3));
            end
            tick();
        end
        checks++;
        if (bus.wr_to_l2_valid !== 1'b0 || bus.wb_done !== 1'b0) begin
            errors++;
            $display("FAIL wb_wait: valid=%b done=%b expected 0 / 0",
                     bus.wr_to_l2_valid, bus.wb_done);
        end
        tick();
        bus.wr_complete = 1'b1;
        tick();
        bus.wr_complete = 1'b0;
        checks++;
        if (bus.wb_done !== 1'b1) begin
            errors++;
            $display("FAIL wb_done: got %b expected 1", bus.wb_done);
        end
        tick();
        checks++;
        if (bus.wb_done !== 1'b0 || bus.wb_req_ready !== 1'b1 || wb_pulses - p0 != 1) begin
            errors++;
            $display("FAIL wb_end: done=%b ready=%b pulses=%0d expected 0 / 1 / 1",
                     bus.wb_done, bus.wb_req_ready, wb_pulses - p0);
        end
    endtask

    // WR_TO_L2_READY low for 3 cycles on beat 2; stray WR_COMPLETE during the burst
    task automatic test_wr_backpressure();
        logic [DW-1:0] bt [4];
        int            n;
        int            stalls;
        for (int k = 0; k < 4; k++) bt[k] = {4{32'hE0E0_0000}} + DW'(k);
        bus.wr_to_l2_ready = 1'b1;
        bus.wb_req_valid   = 1'b1;
        bus.wb_addr        = 30'h2C4;
        bus.wb_data        = {bt[3], bt[2], bt[1], bt[0]};
        tick();
        bus.wb_req_valid = 1'b0;
        bus.wr_complete  = 1'b1;
        n      = 0;
        stalls = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if (n == 2 && stalls < 3) begin
                bus.wr_to_l2_ready = 1'b0;
                stalls++;
            end else begin
                bus.wr_to_l2_ready = 1'b1;
            end
            checks++;
            if (bus.wr_to_l2_valid !== 1'b1 || bus.data_to_l2 !== bt[n] ||
                bus.wr_control_to_l2 !== (n == 3) || bus.wr_addr_to_l2 !== 30'h2C0) begin
                errors++;
                $display("FAIL bp_beat: cycle %0d valid=%b data=%h last=%b addr=%h expected 1 / %h / %b / 000002c0",
                         c, bus.wr_to_l2_valid, bus.data_to_l2, bus.wr_control_to_l2,
                         bus.wr_addr_to_l2, bt[n], (n == 3));
            end
            if (bus.wr_to_l2_valid === 1'b1 && bus.wr_to_l2_ready === 1'b1) n++;
            tick();
            bus.wr_complete = 1'b0;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL bp_count: beats accepted %0d expected 4", n);
        end
        checks++;
        if (bus.wr_to_l2_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_extra_beat: valid=%b expected 0", bus.wr_to_l2_valid);
        end
        tick();
        tick();
        checks++;
        if (bus.wb_done !== 1'b0 || bus.wb_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stray_complete: done=%b ready=%b expected 0 / 0",
                     bus.wb_done, bus.wb_req_ready);
        end
        bus.wr_complete = 1'b1;
        tick();
        bus.wr_complete = 1'b0;
        checks++;
        if (bus.wb_done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: got %b expected 1", bus.wb_done);
        end
        tick();
    endtask

    // Refill to a line under writeback waits for WB_DONE; another line proceeds concurrently
    task automatic test_raw_hazard();
        logic [LW-1:0] exp_line;
        int            acc;
        bit            wdone;
        bus.wr_to_l2_ready      = 1'b0;
        bus.rd_addr_to_l2_ready = 1'b1;
        bus.wb_req_valid        = 1'b1;
        bus.wb_addr             = 30'h100;
        bus.wb_data             = {4{128'h0F0F}};
        bus.refill_req_valid    = 1'b1;
        bus.refill_addr         = 30'h10F;
        #1;
        checks++;
        if (bus.wb_req_ready !== 1'b1 || bus.refill_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_hazard: wb_ready=%b refill_ready=%b expected 1 / 0",
                     bus.wb_req_ready, bus.refill_req_ready);
        end
        tick();
        bus.wb_req_valid = 1'b0;
        #1;
        checks++;
        if (bus.refill_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL active_hazard: refill_ready=%b expected 0", bus.refill_req_ready);
        end
        bus.refill_addr = 30'h200;
        #1;
        checks++;
        if (bus.refill_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL other_line_ready: got %b expected 1", bus.refill_req_ready);
        end
        tick();
        bus.refill_req_valid = 1'b0;
        checks++;
        if (bus.rd_addr_to_l2_valid !== 1'b1 || bus.rd_addr_to_l2 !== 30'h200 ||
            bus.wr_to_l2_valid !== 1'b1) begin
            errors++;
            $display("FAIL concurrent: rd_valid=%b rd_addr=%h wr_valid=%b expected 1 / 00000200 / 1",
                     bus.rd_addr_to_l2_valid, bus.rd_addr_to_l2, bus.wr_to_l2_valid);
        end
        tick();
        feed_beats(128'hC0, 1);
        exp_line = {128'hC3, 128'hC2, 128'hC1, 128'hC0};
        checks++;
        if (bus.refill_done !== 1'b1 || bus.refill_data !== exp_line) begin
            errors++;
            $display("FAIL concurrent_refill: done=%b data=%h expected 1 / %h",
                     bus.refill_done, bus.refill_data, exp_line);
        end
        tick();
        bus.refill_req_valid = 1'b1;
        bus.refill_addr      = 30'h10F;
        bus.wr_to_l2_ready   = 1'b1;
        acc   = 0;
        wdone = 1'b0;
        #1;
        for (int c = 0; c < 40 && !wdone; c++) begin
            checks++;
            if (bus.refill_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL held_off: cycle %0d refill_ready=%b expected 0",
                         c, bus.refill_req_ready);
            end
            if (bus.wb_done === 1'b1) wdone = 1'b1;
            bus.wr_complete = (acc == 4) && !wdone;
            if (bus.wr_to_l2_valid === 1'b1) acc++;
            tick();
            #1;
        end
        bus.wr_complete = 1'b0;
        checks++;
        if (!wdone) begin
            errors++;
            $display("FAIL hazard_wb_done: WB_DONE not seen within 40 cycles");
        end
        checks++;
        if (bus.refill_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL released: refill_ready=%b expected 1", bus.refill_req_ready);
        end
        tick();
        bus.refill_req_valid = 1'b0;
        checks++;
        if (bus.rd_addr_to_l2_valid !== 1'b1 || bus.rd_addr_to_l2 !== 30'h100) begin
            errors++;
            $display("FAIL held_refill_addr: valid=%b addr=%h expected 1 / 00000100",
                     bus.rd_addr_to_l2_valid, bus.rd_addr_to_l2);
        end
        tick();
        feed_beats(128'h70, 0);
        exp_line = {128'h73, 128'h72, 128'h71, 128'h70};
        checks++;
        if (bus.refill_done !== 1'b1 || bus.refill_data !== exp_line) begin
            errors++;
            $display("FAIL held_refill_data: done=%b data=%h expected 1 / %h",
                     bus.refill_done, bus.refill_data, exp_line);
        end
        tick();
    endtask

    // Reset after beat 1 of a refill: no DONE, outputs cleared, next refill completes
    task automatic test_reset_mid_burst();
        logic [LW-1:0] exp_line;
        int            p0;
        bus.rd_addr_to_l2_ready = 1'b1;
        bus.refill_req_valid    = 1'b1;
        bus.refill_addr         = 30'h40;
        tick();
        bus.refill_req_valid = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.data_from_l2_valid = 1'b1;
            bus.data_from_l2       = 128'h90 + DW'(k);
            tick();
        end
        bus.data_from_l2_valid = 1'b0;
        p0  = refill_pulses;
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.refill_req_ready, bus.wb_req_ready, bus.data_from_l2_ready,
             bus.rd_addr_to_l2_valid, bus.refill_done} !== 5'b00000 ||
            bus.refill_data !== '0 || bus.rd_addr_to_l2 !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ctrl=%b data=%h addr=%h expected 00000 / 0 / 0",
                     {bus.refill_req_ready, bus.wb_req_ready, bus.data_from_l2_ready,
                      bus.rd_addr_to_l2_valid, bus.refill_done},
                     bus.refill_data, bus.rd_addr_to_l2);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (refill_pulses - p0 != 0 || bus.refill_req_ready !== 1'b0 + 1'b1) begin
            errors++;
            $display("FAIL mid_reset_no_done: pulses=%0d ready=%b expected 0 / 1",
                     refill_pulses - p0, bus.refill_req_ready);
        end
        bus.refill_req_valid = 1'b1;
        bus.refill_addr      = 30'h40;
        tick();
        bus.refill_req_valid = 1'b0;
        checks++;
        if (bus.rd_addr_to_l2_valid !== 1'b1 || bus.rd_addr_to_l2 !== 30'h40) begin
            errors++;
            $display("FAIL post_reset_addr: valid=%b addr=%h expected 1 / 00000040",
                     bus.rd_addr_to_l2_valid, bus.rd_addr_to_l2);
        end
        tick();
        feed_beats(128'h50, 2);
        exp_line = {128'h53, 128'h52, 128'h51, 128'h50};
        checks++;
        if (bus.refill_done !== 1'b1 || bus.refill_data !== exp_line) begin
            errors++;
            $display("FAIL post_reset_refill: done=%b data=%h expected 1 / %h",
                     bus.refill_done, bus.refill_data, exp_line);
        end
        tick();
        checks++;
        if (refill_pulses - p0 != 1) begin
            errors++;
            $display("FAIL post_reset_pulses: got %0d expected 1", refill_pulses - p0);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_refill();
        test_stray_beats();
        test_writeback();
        test_wr_backpressure();
        test_raw_hazard();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
